program_loader: RTL and testbench

- Boot-time stage directly upstream of the single-cycle RV32I core and its instruction memory.
- Accepts a framed byte stream from the UART receiver and assembles little-endian 32-bit instruction words.
- Writes those words into instruction memory through its write port.
- Holds the core in reset until a complete frame with a valid checksum has loaded.

---
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: receives a framed UART byte stream, writes little-endian words into instruction memory,
// and keeps the core in reset until a frame with a valid checksum has fully loaded.
module program_loader #(
    parameter int          XLEN           = 32,
    parameter int          MEMORY_DEPTH   = 1024,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  MAGIC_BYTE     = 8'hA5
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic [7:0]      i_Rx_Data,
    input  logic            i_Rx_Valid,
    output logic            o_Rx_Ready,
    input  logic            i_Restart,
    output logic            o_Imem_Write_Enable,
    output logic [XLEN-1:0] o_Imem_Write_Addr,
    output logic [XLEN-1:0] o_Imem_Write_Data,
    output logic            o_Cpu_Reset,
    output logic            o_Load_Done,
    output logic            o_Load_Error
);
    localparam int WIW = $clog2(MEMORY_DEPTH + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;

    state_t            state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [WIW-1:0]    word_idx_q, word_idx_d;
    logic [31:0]       word_q, word_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              accept;
    logic              active;
    logic [15:0]       len_full;

    assign o_Rx_Ready          = (state_q != S_DONE) && (state_q != S_ERROR);
    assign accept              = i_Rx_Valid && o_Rx_Ready;
    assign active              = o_Rx_Ready && (state_q != S_IDLE);
    assign len_full            = {i_Rx_Data, len_q[7:0]};
    assign o_Imem_Write_Enable = we_q;
    assign o_Imem_Write_Addr   = waddr_q;
    assign o_Imem_Write_Data   = wdata_q;
    assign o_Cpu_Reset         = cpu_reset_q;
    assign o_Load_Done         = done_q;
    assign o_Load_Error        = error_q;

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        timer_d    = '0;
        case (state_q)
            S_IDLE: if (accept && i_Rx_Data == MAGIC_BYTE) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) begin
                len_d[7:0] = i_Rx_Data;
                sum_d      = sum_q + i_Rx_Data;
                state_d    = S_LEN_HI;
            end
            S_LEN_HI: if (accept) begin
                len_d   = len_full;
                sum_d   = sum_q + i_Rx_Data;
                state_d = (32'(len_full) > MEMORY_DEPTH) ? S_ERROR : (len_full == 16'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: if (accept) begin
                word_d[{byte_idx_q, 3'b000} +: 8] = i_Rx_Data;
                sum_d      = sum_q + i_Rx_Data;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    we_d       = 1'b1;
                    waddr_d    = XLEN'({word_idx_q, 2'b00});
                    wdata_d    = XLEN'({i_Rx_Data, word_q[23:0]});
                    word_idx_d = word_idx_q + WIW'(1);
                    if (16'(word_idx_q) + 16'd1 == len_q) state_d = S_CSUM;
                end
            end
            S_CSUM: if (accept) state_d = (i_Rx_Data == sum_q) ? S_DONE : S_ERROR;
            default: if (i_Restart) begin
                state_d    = S_IDLE;
                sum_d      = '0;
                len_d      = '0;
                byte_idx_d = '0;
                word_idx_d = '0;
                word_d     = '0;
            end
        endcase
        // An accepted byte in the final idle cycle wins over the timeout.
        if (active && !accept) begin
            timer_d = timer_q + TW'(1);
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) state_d = S_ERROR;
        end
        if (state_d != state_q) timer_d = '0;
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
        cpu_reset_d = (state_d != S_DONE);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            len_q       <= '0;
            byte_idx_q  <= '0;
            word_idx_q  <= '0;
            word_q      <= '0;
            timer_q     <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            word_q      <= word_d;
            timer_q     <= timer_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized frames checked against a frame-level model of the
// expected memory writes and final load status.
module tb_program_loader;
    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b0;
    logic [7:0]  i_Rx_Data = 8'h00;
    logic        i_Rx_Valid = 1'b0;
    logic        o_Rx_Ready;
    logic        i_Restart = 1'b0;
    logic        o_Imem_Write_Enable;
    logic [31:0] o_Imem_Write_Addr;
    logic [31:0] o_Imem_Write_Data;
    logic        o_Cpu_Reset;
    logic        o_Load_Done;
    logic        o_Load_Error;

    int checks = 0;
    int errors = 0;
    logic [63:0] got[$];

    always #5 i_Clock = ~i_Clock;

    program_loader #(.TIMEOUT_CYCLES(100)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_Data(i_Rx_Data), .i_Rx_Valid(i_Rx_Valid),
        .o_Rx_Ready(o_Rx_Ready), .i_Restart(i_Restart), .o_Imem_Write_Enable(o_Imem_Write_Enable),
        .o_Imem_Write_Addr(o_Imem_Write_Addr), .o_Imem_Write_Data(o_Imem_Write_Data),
        .o_Cpu_Reset(o_Cpu_Reset), .o_Load_Done(o_Load_Done), .o_Load_Error(o_Load_Error)
    );

    always @(negedge i_Clock) if (o_Imem_Write_Enable) got.push_back({o_Imem_Write_Addr, o_Imem_Write_Data});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_Rx_Valid = 1'b1;
        i_Rx_Data  = b;
        @(negedge i_Clock);
        if (gap > 0) begin
            i_Rx_Valid = 1'b0;
            repeat (gap) @(negedge i_Clock);
        end
    endtask

    task automatic send_frame(input logic [31:0] words[$], input logic [7:0] csum_xor, input int mingap, input int maxgap);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        logic [15:0] len;
        len = 16'(words.size());
        bytes = '{8'hA5, len[7:0], len[15:8]};
        foreach (words[i]) for (int k = 0; k < 4; k++) bytes.push_back(8'(words[i] >> (8 * k)));
        sum = 8'h00;
        for (int i = 1; i < bytes.size(); i++) sum = sum + bytes[i];
        bytes.push_back(sum ^ csum_xor);
        got.delete();
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(maxgap, mingap));
        i_Rx_Valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] words[$], input bit good);
        check({tag, " nwrites"}, 64'(got.size()), 64'(words.size()));
        foreach (words[i]) check({tag, " write"}, (i < got.size()) ? got[i] : 64'hx, {32'(4 * i), words[i]});
        check({tag, " done"}, 64'(o_Load_Done), 64'(good));
        check({tag, " error"}, 64'(o_Load_Error), 64'(!good));
        check({tag, " cpu_reset"}, 64'(o_Cpu_Reset), 64'(!good));
        check({tag, " ready"}, 64'(o_Rx_Ready), 64'd0);
    endtask

    task automatic restart();
        i_Restart = 1'b1;
        @(negedge i_Clock);
        i_Restart = 1'b0;
        check("restart flags", {o_Load_Done, o_Load_Error, o_Cpu_Reset, o_Rx_Ready}, 4'b0011);
    endtask

    initial begin
        logic [31:0] t1[$];
        logic [31:0] none[$];
        logic [31:0] rw[$];
        bit good;
        t1 = '{32'h00000013, 32'h00100093};
        #1 i_Reset = 1'b1;
        #1 check("reset outputs", {o_Rx_Ready, o_Cpu_Reset, o_Imem_Write_Enable, o_Load_Done, o_Load_Error,
                                   o_Imem_Write_Addr, o_Imem_Write_Data}, {5'b11000, 64'd0});
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;

        send_frame(t1, 8'h00, 0, 0);
        check_frame("t1 back-to-back", t1, 1'b1);
        restart();
        send_frame(t1, 8'h00, 3, 3);
        check_frame("t1 gaps", t1, 1'b1);
        restart();

        send_frame(t1, 8'h0F, 0, 1);
        check_frame("t2 bad csum", t1, 1'b0);
        restart();
        send_frame(t1, 8'h00, 0, 1);
        check_frame("t2 resend", t1, 1'b1);
        restart();

        got.delete();
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h04, 0);
        i_Rx_Valid = 1'b0;
        check_frame("t3 too long", none, 1'b0);
        restart();

        send_byte(8'h00, 1); send_byte(8'hFF, 0); send_byte(8'h5A, 2);
        i_Rx_Valid = 1'b0;
        check("t4 junk ready", {o_Rx_Ready, o_Load_Error}, 2'b10);
        send_frame(t1, 8'h00, 0, 2);
        check_frame("t4 after junk", t1, 1'b1);
        restart();

        got.delete();
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h00, 0);
        i_Rx_Valid = 1'b0;
        repeat (99) @(negedge i_Clock);
        check("t5 no timeout at 99", 64'(o_Load_Error), 64'd0);
        @(negedge i_Clock);
        check_frame("t5 timeout at 100", none, 1'b0);
        restart();
        send_frame(none, 8'h00, 0, 0);
        check_frame("t5 len0", none, 1'b1);
        restart();

        got.delete();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h00, 0);
        i_Rx_Valid = 1'b0;
        #2 i_Reset = 1'b1;
        #1 check("t6 async reset", {o_Rx_Ready, o_Cpu_Reset, o_Imem_Write_Enable, o_Load_Done, o_Load_Error}, 5'b11000);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        repeat (3) @(negedge i_Clock);
        check("t6 no write", 64'(got.size()), 64'd0);
        send_frame(t1, 8'h00, 0, 1);
        check_frame("t6 full frame", t1, 1'b1);
        restart();

        for (int n = 0; n < 20; n++) begin
            rw.delete();
            repeat ($urandom_range(6, 1)) rw.push_back($urandom);
            good = ($urandom_range(3, 0) != 0);
            send_frame(rw, good ? 8'h00 : 8'($urandom_range(255, 1)), 0, 3);
            check_frame("random frame", rw, good);
            restart();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
